mxint8_block_decoder: RTL and testbench
=======================================

# mxint8_block_decoder

Converts one MXINT8 block back into IEEE-754 float32 values. Input is a shared E8M0 scale plus BLOCK_SIZE INT8 elements. Output is a stream of BLOCK_SIZE float32 values, one per cycle, under valid/ready flow control. It is the receive-side counterpart of the MXINT8 broadcast encoder: it sits between MX storage or transport and any float32 consumer, and in bench loopback it sits behind the encoder.

## Interface
- BLOCK_SIZE, 32, elements per MX block (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_scale  in  8  shared E8M0 scale, bias 127; 0xFF means NaN
- i_mxint8_elements  in  8 × [BLOCK_SIZE]  two's-complement elements, 6 fraction bits (value = int8/64)
- i_valid  in  1  input block valid
- o_ready  out  1  decoder can accept a block
- o_float32  out  32  decoded element
- o_index  out  $clog2(BLOCK_SIZE)  element index of o_float32
- o_last  out  1  o_float32 is element BLOCK_SIZE-1
- o_valid  out  1  output element valid
- i_ready  in  1  downstream accepts the element

## Operation
- FSM states: IDLE and EMIT.
- IDLE:
  - o_ready=1.
  - When i_valid&o_ready: capture scale and all elements, set idx=0, go to EMIT.
- EMIT:
  - o_valid=1.
  - o_float32 = convert(elem[idx], scale).
  - On o_valid&i_ready: idx+1.
  - On the handshake with idx=BLOCK_SIZE-1: if i_valid, capture the new block, set idx=0 and stay in EMIT; otherwise go to IDLE.
- o_ready = IDLE, or (EMIT & idx==BLOCK_SIZE-1 & i_ready). This is a combinational path from i_ready.
- o_float32, o_index and o_last depend only on registered state. There is no path from i_scale or the elements to the outputs.
- When o_valid=0: o_float32=0, o_index=0, o_last=0.
- Conversion rules, with s=elem[7], mag=|elem| (1..128, 9-bit intermediate) and p = leading-one position of mag (0..7):
  - Scale 0xFF: output 0x7FC00000 regardless of element.
  - elem==0: output 0x00000000.
  - Otherwise e = scale + p − 6, computed as a signed 10-bit value.
  - Normal case (1 ≤ e ≤ 254): sign=s, exp=e, frac = bits below the leading one, left-aligned into 23 bits.
  - e ≥ 255 (only scale=254, elem=0x80): output ±infinity, i.e. {s, 8'hFF, 23'h0}.
  - e ≤ 0: subnormal case; see Configuration.
  - No rounding is ever required; all results are exact.
- Reset mid-block: the block is discarded, state goes to IDLE, and no partial output appears afterward.

## Timing
- Reset values: state=IDLE, idx=0, o_valid=0, o_ready=1, o_float32=0, o_index=0, o_last=0. Reset acts immediately when asserted (asynchronous).
- Latency: a block accepted at edge N gives o_valid=1 with element 0 in the cycle after edge N.
- Throughput: with i_ready held high, one element per cycle. Back-to-back blocks produce BLOCK_SIZE×k elements in BLOCK_SIZE×k cycles with no bubble.
- Under backpressure (i_ready=0), o_float32, o_index and o_last hold stable.
- Simultaneous last-element handshake and new-block handshake: both complete at the same edge. The next cycle shows element 0 of the new block.

## Configuration
- MXINT8_DEC_SUBNORM_EN defined: for e ≤ 0, output {s, 8'h00, mag << (scale+16)}. This is an exact float32 subnormal; since scale+p ≤ 6, the value fits in 23 bits.
- MXINT8_DEC_SUBNORM_EN undefined: for e ≤ 0, flush to signed zero, {s, 31'h0}.

## Structure
- Package mxint8_pkg holds:
  - SCALE_WIDTH=8, MXINT8_ELEMENT_WIDTH=8, FLOAT32_WIDTH=32
  - E8M0_BIAS=127, E8M0_NAN=8'hFF
  - FP32_QNAN=32'h7FC00000
  - the FSM state enum
- Sub-module mxint8_elem_to_fp32: purely combinational single-element converter (element, scale → float32). It holds all conversion rules and the subnormal macro.
- The top-level block holds the FSM, index counter, capture registers and handshake logic.

## Test plan
- Scale 127; elements 0x40, 0xC0, 0x01, 0x00 → 0x3F800000, 0xBF800000, 0x3C800000, 0x00000000.
- Scale 0xFF with arbitrary elements → all BLOCK_SIZE outputs 0x7FC00000; o_last set only on index 31.
- Scale 254; element 0x80 → 0xFF800000; element 0x7F → 0x7F7E0000.
- Scale 0; elements 0x01 and 0x81:
  - with MXINT8_DEC_SUBNORM_EN → 0x00010000 and 0x807F0000;
  - without it → 0x00000000 and 0x80000000.
- Two blocks with i_valid held high and i_ready=1 → 64 elements in 64 consecutive cycles, o_index wraps 31→0 with no bubble. Then random i_ready toggling → outputs hold while stalled, order preserved.
- rst pulsed while o_index=10 → o_valid drops immediately and o_ready=1 after release. The next block starts at index 0, and no stale elements appear.

Source files
------------

// File: rtl/mxint8_pkg.sv
// Shared widths, encodings and FSM state type for the MXINT8 block decoder.
package mxint8_pkg;

  localparam int SCALE_WIDTH          = 8;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int FLOAT32_WIDTH        = 32;

  localparam logic [SCALE_WIDTH-1:0]   E8M0_BIAS = 8'd127;
  localparam logic [SCALE_WIDTH-1:0]   E8M0_NAN  = 8'hFF;
  localparam logic [FLOAT32_WIDTH-1:0] FP32_QNAN = 32'h7FC00000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/mxint8_elem_to_fp32.sv
// Combinational MXINT8 element + E8M0 scale to float32 converter.
// MXINT8_DEC_SUBNORM_EN: emit exact float32 subnormals instead of flushing to signed zero.
module mxint8_elem_to_fp32
  import mxint8_pkg::*;
(
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] element,
  input  logic [SCALE_WIDTH-1:0]          scale,
  output logic [FLOAT32_WIDTH-1:0]        result
);

  logic              sign_s;
  logic [7:0]        mag_s;
  logic [2:0]        lead_s;
  logic signed [9:0] exp_s;
  logic [22:0]       norm_frac_s;
  logic [22:0]       sub_frac_s;

  // Magnitude, leading-one position and unbiased exponent arithmetic.
  always_comb begin
    sign_s = element[7];
    // 0 - 0x80 wraps to 0x80, which is exactly the magnitude 128
    if (sign_s) begin
      mag_s = 8'd0 - element;
    end else begin
      mag_s = element;
    end
    lead_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mag_s[i]) begin
        lead_s = 3'(i);
      end else begin
        lead_s = lead_s;
      end
    end
    exp_s       = $signed({2'b00, scale}) + $signed({7'd0, lead_s}) - 10'sd6;
    norm_frac_s = {15'd0, mag_s} << (5'd23 - {2'b00, lead_s});
    sub_frac_s  = {15'd0, mag_s} << ({1'b0, scale[3:0]} + 5'd16);
  end

  // Select the special-case or normal/subnormal encoding.
  always_comb begin
    if (scale == E8M0_NAN) begin
      result = FP32_QNAN;
    end else if (element == 8'h00) begin
      result = 32'h0000_0000;
    end else if (exp_s >= 10'sd255) begin
      result = {sign_s, 8'hFF, 23'h0};
    end else if (exp_s >= 10'sd1) begin
      result = {sign_s, exp_s[7:0], norm_frac_s};
    end else begin
`ifdef MXINT8_DEC_SUBNORM_EN
      result = {sign_s, 8'h00, sub_frac_s};
`else
      result = {sign_s, 31'h0};
`endif
    end
  end

`ifndef MXINT8_DEC_SUBNORM_EN
  logic unused_sub_s;
  assign unused_sub_s = ^sub_frac_s;
`endif

endmodule

// File: rtl/mxint8_block_decoder.sv
// Captures one MXINT8 block (E8M0 scale + BLOCK_SIZE int8) and streams it out
// as float32 elements, one per handshake, with zero-bubble block chaining.
module mxint8_block_decoder
  import mxint8_pkg::*;
#(
  parameter int BLOCK_SIZE = 32
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [SCALE_WIDTH-1:0]                              i_scale,
  input  logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]     i_mxint8_elements,
  input  logic                                                i_valid,
  output logic                                                o_ready,
  output logic [FLOAT32_WIDTH-1:0]                            o_float32,
  output logic [$clog2(BLOCK_SIZE)-1:0]                       o_index,
  output logic                                                o_last,
  output logic                                                o_valid,
  input  logic                                                i_ready
);

  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  state_t                                          state_r;
  state_t                                          state_nxt_s;
  logic [IDX_W-1:0]                                idx_r;
  logic [SCALE_WIDTH-1:0]                          scale_r;
  logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] elems_r;
  logic                                            at_last_s;
  logic                                            accept_s;
  logic                                            fire_s;
  logic [FLOAT32_WIDTH-1:0]                        conv_s;

  mxint8_elem_to_fp32 u_conv (
    .element (elems_r[idx_r]),
    .scale   (scale_r),
    .result  (conv_s)
  );

  // Handshake qualifiers shared by the FSM and datapath.
  always_comb begin
    at_last_s = (state_r == ST_EMIT) && (idx_r == LAST_IDX);
    accept_s  = i_valid && o_ready;
    fire_s    = o_valid && i_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (fire_s && at_last_s && !accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Block capture and element index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= '0;
      scale_r <= 8'd0;
      elems_r <= '0;
    end else if (accept_s) begin
      idx_r   <= '0;
      scale_r <= i_scale;
      elems_r <= i_mxint8_elements;
    end else if (fire_s) begin
      idx_r <= at_last_s ? '0 : idx_r + 1'b1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Output decode; o_ready is the only output that sees i_ready.
  always_comb begin
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_float32 = 32'h0000_0000;
    o_index   = '0;
    o_last    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        o_ready = 1'b1;
      end
      ST_EMIT: begin
        o_ready   = at_last_s && i_ready;
        o_valid   = 1'b1;
        o_float32 = conv_s;
        o_index   = idx_r;
        o_last    = at_last_s;
      end
      default: begin
        o_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mxint8_block_decoder.sv
// Randomised self-checking bench for mxint8_block_decoder against a real-arithmetic model.
module tb_mxint8_block_decoder;

  localparam int BS = 32;

  typedef struct packed {
    logic [31:0] f;
    logic [4:0]  idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           scale_in = 8'd0;
  logic [BS-1:0][7:0]   elems_in = '0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [31:0]          o_float32;
  logic [4:0]           o_index;
  logic                 o_last;
  logic                 o_valid;
  logic                 i_ready = 1'b1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];
  exp_t exp_head;

  mxint8_block_decoder #(.BLOCK_SIZE(BS)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_scale           (scale_in),
    .i_mxint8_elements (elems_in),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .o_float32         (o_float32),
    .o_index           (o_index),
    .o_last            (o_last),
    .o_valid           (o_valid),
    .i_ready           (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) begin
      for (int k = 0; k < n; k++) r = r * 2.0;
    end else begin
      for (int k = 0; k < -n; k++) r = r * 0.5;
    end
    return r;
  endfunction

  // Value = int8/64 * 2^(scale-127), encoded via the double-precision bit pattern.
  function automatic logic [31:0] ref_convert(input logic [7:0] e, input logic [7:0] sc);
    int          iv;
    real         v;
    logic [63:0] b;
    int          de;
    logic        s;
    int          m;
    if (sc == 8'hFF) return 32'h7FC00000;
    iv = int'($signed(e));
    if (iv == 0) return 32'h0000_0000;
    s  = (iv < 0);
    v  = real'(s ? -iv : iv) * pow2(int'(sc) - 133);
    b  = $realtobits(v);
    de = int'(b[62:52]) - 1023;
    if (de > 127) return {s, 8'hFF, 23'h0};
    if (de >= -126) return {s, 8'(de + 127), b[51:29]};
`ifdef MXINT8_DEC_SUBNORM_EN
    m = $rtoi(v * pow2(149));
    return {s, 8'h00, 23'(m)};
`else
    m = 0;
    return {s, 31'(m)};
`endif
  endfunction

  // Downstream ready: steady high or random backpressure.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) i_ready = 1'b1;
    else i_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: pending expectations imply a valid element in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) begin
        check_eq("valid_pending", 32'(o_valid), 32'd1);
        if (o_valid) begin
          exp_head = exp_q[0];
          check_eq("float32", o_float32, exp_head.f);
          check_eq("index", 32'(o_index), 32'(exp_head.idx));
          check_eq("last", 32'(o_last), 32'(exp_head.idx == 5'd31));
          if (i_ready) void'(exp_q.pop_front());
        end
      end else begin
        check_eq("idle_valid", 32'(o_valid), 32'd0);
        check_eq("idle_float32", o_float32, 32'd0);
        check_eq("idle_index", 32'(o_index), 32'd0);
        check_eq("idle_last", 32'(o_last), 32'd0);
      end
    end
  end

  // Present a block (called at posedge+1) and wait for it to be accepted.
  task automatic send_block(input logic [7:0] sc, input logic [BS-1:0][7:0] el);
    bit ok;
    ok = 1'b0;
    scale_in = sc;
    elems_in = el;
    i_valid  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    if (ok) begin
      for (int i = 0; i < BS; i++) exp_q.push_back({ref_convert(el[i], sc), 5'(i)});
    end
    #1;
  endtask

  task automatic end_stream();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BS-1:0][7:0] rand_elems();
    logic [BS-1:0][7:0] r;
    for (int i = 0; i < BS; i++) r[i] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    logic [BS-1:0][7:0] el;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_float32", o_float32, 32'd0);
    check_eq("rst_index", 32'(o_index), 32'd0);
    check_eq("rst_last", 32'(o_last), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    el = rand_elems();
    el[0] = 8'h40; el[1] = 8'hC0; el[2] = 8'h01; el[3] = 8'h00;
    send_block(8'd127, el); end_stream(); drain();

    send_block(8'hFF, rand_elems()); end_stream(); drain();

    el = rand_elems();
    el[0] = 8'h80; el[1] = 8'h7F;
    send_block(8'd254, el); end_stream(); drain();

    el = rand_elems();
    el[0] = 8'h01; el[1] = 8'h81;
    send_block(8'd0, el); end_stream(); drain();

    // back-to-back blocks with steady ready: no bubble across the 31->0 wrap
    send_block(8'($urandom_range(0, 254)), rand_elems());
    send_block(8'($urandom_range(0, 254)), rand_elems());
    end_stream(); drain();

    ready_mode = 1;
    for (int b = 0; b < 6; b++) begin
      send_block((b % 2 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255)), rand_elems());
    end
    end_stream(); drain();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // reset in the middle of a block
    send_block(8'd127, rand_elems()); end_stream();
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_valid && o_index == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_index10", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq("midrst_valid", 32'(o_valid), 32'd0);
    check_eq("midrst_ready", 32'(o_ready), 32'd1);
    check_eq("midrst_index", 32'(o_index), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("postrst_ready", 32'(o_ready), 32'd1);
    check_eq("postrst_valid", 32'(o_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    send_block(8'($urandom_range(100, 150)), rand_elems()); end_stream(); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
